multi_mode_ff_bank: RTL and testbench

- Parametrised bank of WIDTH flip-flops sharing one clock.
- A run-time `mode` input selects D, T, JK or SR next-state behaviour for all bits.
- Configurable policy for the illegal SR=11 input, plus a sticky error flag and a saturating error counter.
- Generalises the team's single-bit SR-to-T conversion flip-flop into a reusable multi-bit, multi-mode state element for counters and control registers.

---
 rtl/ff_bank_pkg.sv | 17 +
 rtl/ff_bit_next.sv | 46 ++++
 rtl/multi_mode_ff_bank.sv | 84 ++++++++
 tb/tb_multi_mode_ff_bank.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// Shared types and constants for the multi-mode flip-flop bank.
package ff_bank_pkg;

    // Run-time next-state behaviour applied to every bit of the bank.
    typedef enum logic [1:0] {
        FF_D  = 2'b00,
        FF_T  = 2'b01,
        FF_JK = 2'b10,
        FF_SR = 2'b11
    } ff_mode_e;

    // Next state of a bit that sees S=1,R=1 in SR mode.
    localparam int SR_HOLD  = 0;
    localparam int SR_SET   = 1;
    localparam int SR_RESET = 2;

endpackage

// File: rtl/ff_bit_next.sv
// Combinational next-state function for one flip-flop bit in any mode.
module ff_bit_next
    import ff_bank_pkg::*;
(
    input  logic       q,
    input  logic       a,
    input  logic       b,
    input  ff_mode_e   mode,
    input  logic [1:0] policy,
    output logic       q_next
);

    // Select next state from the current mode and the a/b bit pair.
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives q_next, so no latch is inferred.
        q_next = q;
        case (mode)
            FF_D:  q_next = a;
            FF_T:  q_next = q ^ a;
            FF_JK: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            FF_SR: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11: begin
                        case (policy)
                            2'(SR_SET):   q_next = 1'b1;
                            2'(SR_RESET): q_next = 1'b0;
                            default:      q_next = q;
                        endcase
                    end
                    default: q_next = q;
                endcase
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops with run-time D/T/JK/SR mode, illegal-SR detection,
// a sticky error flag and a saturating error counter.
module multi_mode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int                 WIDTH             = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE       = '0,
    parameter int                 SR_ILLEGAL_POLICY = 0,
    parameter int                 ERR_CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sync_clr,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn,
    output logic                 sr_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [1:0]           POLICY      = SR_ILLEGAL_POLICY[1:0];
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Reject an undefined SR=11 policy when the design is elaborated.
    if (SR_ILLEGAL_POLICY < SR_HOLD || SR_ILLEGAL_POLICY > SR_RESET) begin : g_bad_policy
        $error("multi_mode_ff_bank: SR_ILLEGAL_POLICY must be 0, 1 or 2");
    end

    ff_mode_e         mode_e;
    logic [WIDTH-1:0] q_next;
    logic             illegal;

    assign mode_e = ff_mode_e'(mode);

    // One next-state cell per bit; all share the mode and policy.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_bit_next u_bit (
            .q      (q[i]),
            .a      (a[i]),
            .b      (b[i]),
            .mode   (mode_e),
            .policy (POLICY),
            .q_next (q_next[i])
        );
    end

    // An illegal event is any bit with S=R=1 on a cycle that actually updates in SR mode.
    assign illegal = en && (mode_e == FF_SR) && !sync_clr && (|(a & b));

    assign qn = ~q;

    // State register: reset > sync_clr > en > hold.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, avoiding ordering races.
        if (reset) begin
            q <= RESET_VALUE;
        end else if (sync_clr) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= q_next;
        end
    end

    // Sticky error flag and saturating counter; a same-cycle event beats err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_err  <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            sr_err  <= illegal;
            err_cnt <= ERR_CNT_W'(illegal);
        end else if (illegal) begin
            sr_err <= 1'b1;
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed self-checking bench for multi_mode_ff_bank. Four instances share the
// stimulus: policy 0/1/2 with an 8-bit counter, and policy 0 with a 2-bit counter.
module tb_multi_mode_ff_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       sync_clr;
    logic       err_clr;

    logic [7:0] q0, qn0, q1, qn1, q2, qn2, q3, qn3;
    logic       err0, err1, err2, err3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_ILLEGAL_POLICY(0), .ERR_CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sync_clr(sync_clr),
        .err_clr(err_clr), .q(q0), .qn(qn0), .sr_err(err0), .err_cnt(cnt0));

    multi_mode_ff_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_ILLEGAL_POLICY(1), .ERR_CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sync_clr(sync_clr),
        .err_clr(err_clr), .q(q1), .qn(qn1), .sr_err(err1), .err_cnt(cnt1));

    multi_mode_ff_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_ILLEGAL_POLICY(2), .ERR_CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sync_clr(sync_clr),
        .err_clr(err_clr), .q(q2), .qn(qn2), .sr_err(err2), .err_cnt(cnt2));

    multi_mode_ff_bank #(.WIDTH(8), .RESET_VALUE(8'hA5), .SR_ILLEGAL_POLICY(0), .ERR_CNT_W(2)) dut3 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b), .sync_clr(sync_clr),
        .err_clr(err_clr), .q(q3), .qn(qn3), .sr_err(err3), .err_cnt(cnt3));

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's worth of inputs (applied away from the edge).
    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] va,
                         input logic [7:0] vb, input logic sc, input logic ec);
        en = e; mode = m; a = va; b = vb; sync_clr = sc; err_clr = ec;
    endtask

    task automatic test_reset();
        // Power-on reset values.
        checks++; if (q0 !== 8'hA5) begin failures++; $display("FAIL por_q got=%h exp=a5", q0); end
        checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0) begin failures++; $display("FAIL por_err got=%b/%0d exp=0/0", err0, cnt0); end
        // One illegal cycle (bit0 S=R=1, q bit0 already 1, hold) so the error state is non-zero.
        drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0, 1'b0); tick();
        // Load q=3C in D mode.
        drive(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h3C) begin failures++; $display("FAIL load_3c got=%h exp=3c", q0); end
        checks++; if (err0 !== 1'b1 || cnt0 !== 8'd1) begin failures++; $display("FAIL pre_reset_err got=%b/%0d exp=1/1", err0, cnt0); end
        // Mid-cycle reset pulse: effect must be visible before any edge.
        #2 reset = 1'b1;
        #1;
        checks++; if (q0 !== 8'hA5) begin failures++; $display("FAIL async_reset_q got=%h exp=a5", q0); end
        checks++; if (qn0 !== 8'h5A) begin failures++; $display("FAIL async_reset_qn got=%h exp=5a", qn0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL async_reset_sr_err got=%b exp=0", err0); end
        checks++; if (cnt0 !== 8'd0 || cnt3 !== 2'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt3); end
        #1 reset = 1'b0;
    endtask

    task automatic test_t_mode();
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h00) begin failures++; $display("FAIL t_init got=%h exp=00", q0); end
        drive(1'b1, 2'b01, 8'h0F, 8'h00, 1'b0, 1'b0);
        tick(); checks++; if (q0 !== 8'h0F) begin failures++; $display("FAIL t_edge1 got=%h exp=0f", q0); end
        tick(); checks++; if (q0 !== 8'h00) begin failures++; $display("FAIL t_edge2 got=%h exp=00", q0); end
        tick(); checks++; if (q0 !== 8'h0F) begin failures++; $display("FAIL t_edge3 got=%h exp=0f", q0); end
        en = 1'b0;
        tick(); checks++; if (q0 !== 8'h0F) begin failures++; $display("FAIL t_hold1 got=%h exp=0f", q0); end
        tick(); checks++; if (q0 !== 8'h0F) begin failures++; $display("FAIL t_hold2 got=%h exp=0f", q0); end
    endtask

    task automatic test_jk_mode();
        drive(1'b1, 2'b00, 8'hF0, 8'h00, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b10, 8'hCC, 8'hAA, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h5C) begin failures++; $display("FAIL jk_q got=%h exp=5c", q0); end
        checks++; if (qn0 !== 8'hA3) begin failures++; $display("FAIL jk_qn got=%h exp=a3", qn0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL jk_no_err got=%b exp=0", err0); end
    endtask

    task automatic test_sr_illegal();
        // Clear errors while loading q=00.
        drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1); tick();
        checks++; if (err0 !== 1'b0 || cnt0 !== 8'd0) begin failures++; $display("FAIL sr_pre_clear got=%b/%0d exp=0/0", err0, cnt0); end
        drive(1'b1, 2'b11, 8'h03, 8'h01, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h02) begin failures++; $display("FAIL sr_policy_hold got=%h exp=02", q0); end
        checks++; if (q1 !== 8'h03) begin failures++; $display("FAIL sr_policy_set got=%h exp=03", q1); end
        checks++; if (q2 !== 8'h02) begin failures++; $display("FAIL sr_policy_reset got=%h exp=02", q2); end
        checks++; if (err1 !== 1'b1 || err2 !== 1'b1) begin failures++; $display("FAIL sr_err_others got=%b%b exp=11", err1, err2); end
        tick(); tick();
        checks++; if (q0 !== 8'h02) begin failures++; $display("FAIL sr_q_after3 got=%h exp=02", q0); end
        checks++; if (err0 !== 1'b1) begin failures++; $display("FAIL sr_err_set got=%b exp=1", err0); end
        checks++; if (cnt0 !== 8'd3) begin failures++; $display("FAIL sr_cnt3 got=%0d exp=3", cnt0); end
        checks++; if (q1 !== 8'h03) begin failures++; $display("FAIL sr_set_stays got=%h exp=03", q1); end
    endtask

    task automatic test_saturation();
        // Two more illegal cycles: five in total since the clear.
        tick(); tick();
        checks++; if (cnt3 !== 2'd3) begin failures++; $display("FAIL sat_no_wrap got=%0d exp=3", cnt3); end
        checks++; if (cnt0 !== 8'd5) begin failures++; $display("FAIL sat_wide_cnt got=%0d exp=5", cnt0); end
        err_clr = 1'b1; tick();
        checks++; if (cnt3 !== 2'd1 || err3 !== 1'b1) begin failures++; $display("FAIL clr_with_event got=%0d/%b exp=1/1", cnt3, err3); end
        checks++; if (cnt0 !== 8'd1 || err0 !== 1'b1) begin failures++; $display("FAIL clr_with_event_w got=%0d/%b exp=1/1", cnt0, err0); end
        en = 1'b0; tick();
        checks++; if (cnt3 !== 2'd0 || err3 !== 1'b0) begin failures++; $display("FAIL clr_alone got=%0d/%b exp=0/0", cnt3, err3); end
        checks++; if (cnt0 !== 8'd0 || err0 !== 1'b0) begin failures++; $display("FAIL clr_alone_w got=%0d/%b exp=0/0", cnt0, err0); end
    endtask

    task automatic test_sync_clr();
        drive(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0, 1'b0); tick();
        drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h3C || cnt0 !== 8'd1) begin failures++; $display("FAIL sc_setup got=%h/%0d exp=3c/1", q0, cnt0); end
        drive(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b1, 1'b0); tick();
        checks++; if (q0 !== 8'hA5) begin failures++; $display("FAIL sc_q got=%h exp=a5", q0); end
        checks++; if (err0 !== 1'b1 || cnt0 !== 8'd1) begin failures++; $display("FAIL sc_err_kept got=%b/%0d exp=1/1", err0, cnt0); end
        // sync_clr with en=1 still masks the illegal event.
        en = 1'b1; tick();
        checks++; if (q0 !== 8'hA5 || cnt0 !== 8'd1) begin failures++; $display("FAIL sc_en_masks got=%h/%0d exp=a5/1", q0, cnt0); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b00, 8'h81, 8'h00, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h81) begin failures++; $display("FAIL b2b_d got=%h exp=81", q0); end
        drive(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h7E) begin failures++; $display("FAIL b2b_t got=%h exp=7e", q0); end
        drive(1'b1, 2'b10, 8'h0F, 8'hF0, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'h0F) begin failures++; $display("FAIL b2b_jk got=%h exp=0f", q0); end
        drive(1'b1, 2'b11, 8'hF0, 8'h0F, 1'b0, 1'b0); tick();
        checks++; if (q0 !== 8'hF0 || err0 !== 1'b1 || cnt0 !== 8'd1) begin failures++; $display("FAIL b2b_sr got=%h/%b/%0d exp=f0/1/1", q0, err0, cnt0); end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_t_mode();
        test_jk_mode();
        test_sr_illegal();
        test_saturation();
        test_sync_clr();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
